// File: rtl/pc_unit_if.sv
// pc_unit_if: control inputs and fetch-address outputs of the program counter unit.
`ifndef WORD
`define WORD [31:0]
`endif
interface pc_unit_if;
  logic stall;
  logic halt;
  logic uncond_branch;
  logic cond_branch;
  logic zero;
  logic reg_branch;
  logic `WORD branch_offset;
  logic `WORD reg_target;
  logic `WORD pc;
  logic `WORD pc_plus4;
  logic valid;
  logic halted;
  logic fault;
  modport master (
    output stall, halt, uncond_branch, cond_branch, zero, reg_branch, branch_offset, reg_target,
    input pc, pc_plus4, valid, halted, fault
  );
  modport slave (
    input stall, halt, uncond_branch, cond_branch, zero, reg_branch, branch_offset, reg_target,
    output pc, pc_plus4, valid, halted, fault
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: BOOT/RUN/HALT program counter with branch selection.
// Define PC_BOUNDS_CHECK_EN to halt with fault on misaligned or out-of-range next pc.
`ifndef WORD
`define WORD [31:0]
`endif
module pc_unit #(
  parameter logic `WORD RESET_PC = '0,
  parameter int IMEM_SIZE = 1024
) (
  input logic clk,
  input logic reset,
  pc_unit_if.slave bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_n;
  logic `WORD pc_q, pc_n, target;
  logic run, adv, bad;
  assign run = state == RUN;
  assign adv = run && !bus.stall;
  assign target = bus.reg_branch ? bus.reg_target
                : (bus.uncond_branch || (bus.cond_branch && bus.zero)) ? pc_q + (bus.branch_offset << 2)
                : pc_q + 32'd4;
`ifdef PC_BOUNDS_CHECK_EN
  logic fault_q;
  assign bad = |target[1:0] || ((target >> 2) >= 32'(IMEM_SIZE));
  always_ff @(posedge clk or posedge reset)
    if (reset) fault_q <= 1'b0;
    else fault_q <= fault_q | (adv && bad);
  assign bus.fault = fault_q;
`else
  assign bad = 1'b0;
  assign bus.fault = 1'b0;
`endif
  always_comb begin
    state_n = state == BOOT ? RUN : (run && (bus.halt || (adv && bad))) ? HALT : state;
    pc_n = (adv && !bus.halt && !bad) ? target : pc_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= BOOT;
      pc_q <= RESET_PC;
    end else begin
      state <= state_n;
      pc_q <= pc_n;
    end
  assign bus.pc = pc_q;
  assign bus.pc_plus4 = pc_q + 32'd4;
  assign bus.valid = run;
  assign bus.halted = state == HALT;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed checks of pc_unit sequencing, branch priority, stall, halt and reset.
module tb_pc_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  pc_unit_if bus();
  pc_unit #(.RESET_PC(32'd0), .IMEM_SIZE(1024)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.stall = 0; bus.halt = 0; bus.uncond_branch = 0; bus.cond_branch = 0;
    bus.zero = 0; bus.reg_branch = 0; bus.branch_offset = '0; bus.reg_target = '0;
  endtask
  task automatic jump(input logic [31:0] t);
    bus.reg_branch = 1; bus.reg_target = t;
    step();
    idle();
  endtask
  task automatic reboot();
    #2 reset = 1;
    #1;
    chk("async_rst_pc", bus.pc, 32'd0);
    chk("async_rst_halted", 32'(bus.halted), 32'd0);
    chk("async_rst_fault", 32'(bus.fault), 32'd0);
    chk("async_rst_valid", 32'(bus.valid), 32'd0);
    step();
    reset = 0;
    step();
  endtask
  initial begin
    idle();
    #2;
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    step();
    reset = 0;
    chk("boot_pc", bus.pc, 32'd0);
    chk("boot_valid", 32'(bus.valid), 32'd0);
    bus.halt = 1; bus.stall = 1; bus.reg_branch = 1; bus.reg_target = 32'h40;
    step();
    idle();
    chk("run0_pc", bus.pc, 32'd0);
    chk("run0_valid", 32'(bus.valid), 32'd1);
    chk("run0_halted", 32'(bus.halted), 32'd0);
    step();
    chk("run1_pc", bus.pc, 32'd4);
    step();
    chk("run2_pc", bus.pc, 32'd8);
    chk("run2_pc4", bus.pc_plus4, 32'd12);
    jump(32'h10);
    chk("jump10", bus.pc, 32'h10);
    bus.uncond_branch = 1; bus.branch_offset = -32'sd2;
    step();
    idle();
    chk("uncond_back", bus.pc, 32'h08);
    jump(32'h10);
    bus.cond_branch = 1; bus.zero = 0; bus.branch_offset = 32'd7;
    step();
    idle();
    chk("cond_not_taken", bus.pc, 32'h14);
    bus.cond_branch = 1; bus.zero = 1; bus.branch_offset = 32'd3;
    step();
    idle();
    chk("cond_taken", bus.pc, 32'h20);
    bus.reg_branch = 1; bus.uncond_branch = 1; bus.reg_target = 32'h100; bus.branch_offset = 32'd5;
    step();
    idle();
    chk("priority_reg", bus.pc, 32'h100);
    chk("pc_plus4_100", bus.pc_plus4, 32'h104);
`ifndef PC_BOUNDS_CHECK_EN
    jump(32'hFFFF_FFFC);
    chk("wrap_pc4", bus.pc_plus4, 32'd0);
    step();
    chk("wrap_pc", bus.pc, 32'd0);
`endif
    jump(32'h0C);
    bus.stall = 1; bus.uncond_branch = 1; bus.branch_offset = 32'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", bus.pc, 32'h0C);
    end
    bus.halt = 1;
    step();
    idle();
    chk("halt_pc", bus.pc, 32'h0C);
    chk("halt_halted", 32'(bus.halted), 32'd1);
    chk("halt_valid", 32'(bus.valid), 32'd0);
    bus.reg_branch = 1; bus.reg_target = 32'h40;
    step();
    step();
    idle();
    chk("halt_frozen", bus.pc, 32'h0C);
    chk("halt_stays", 32'(bus.halted), 32'd1);
    reboot();
    chk("reboot_pc", bus.pc, 32'd0);
    chk("reboot_valid", 32'(bus.valid), 32'd1);
    bus.reg_branch = 1; bus.reg_target = 32'h1000;
    step();
    idle();
`ifdef PC_BOUNDS_CHECK_EN
    chk("oob_pc", bus.pc, 32'd0);
    chk("oob_halted", 32'(bus.halted), 32'd1);
    chk("oob_fault", 32'(bus.fault), 32'd1);
    reboot();
`else
    chk("oob_pc", bus.pc, 32'h1000);
    chk("oob_fault", 32'(bus.fault), 32'd0);
`endif
    bus.reg_branch = 1; bus.reg_target = 32'h102;
    step();
    idle();
`ifdef PC_BOUNDS_CHECK_EN
    chk("misalign_pc", bus.pc, 32'd0);
    chk("misalign_halted", 32'(bus.halted), 32'd1);
    chk("misalign_fault", 32'(bus.fault), 32'd1);
`else
    chk("misalign_pc", bus.pc, 32'h102);
    chk("misalign_fault", 32'(bus.fault), 32'd0);
`endif
    reboot();
    jump(32'h20);
    bus.reg_branch = 1; bus.reg_target = 32'h40;
    #2 reset = 1;
    step();
    chk("rst_mid_branch_pc", bus.pc, 32'd0);
    chk("rst_mid_branch_valid", 32'(bus.valid), 32'd0);
    idle();
    reset = 0;
    step();
    step();
    chk("post_rst_pc", bus.pc, 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, the byte address loaded into the PC on reset.
REQ-002 SHALL have parameter IMEM_SIZE, default 1024, the instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port stall, input, 1; when high, the PC holds.
REQ-006 SHALL have port halt, input, 1; when high, the current instruction is a halt.
REQ-007 SHALL have port uncond_branch, input, 1; when high, the current instruction is B or BL.
REQ-008 SHALL have port cond_branch, input, 1; when high, the current instruction is CBZ, CBNZ or B.cond.
REQ-009 SHALL have port zero, input, 1; when high, the branch condition is taken.
REQ-010 SHALL have port reg_branch, input, 1; when high, the current instruction is BR.
REQ-011 SHALL have port branch_offset, input, `WORD; a sign-extended word offset.
REQ-012 SHALL have port reg_target, input, `WORD; the BR target byte address.
REQ-013 SHALL have port pc, output, `WORD; the byte address driven to instruction memory.
REQ-014 SHALL have port pc_plus4, output, `WORD; the value pc+4, used as the BL link value.
REQ-015 SHALL have port valid, output, 1; when high, pc is a live fetch address.
REQ-016 SHALL have port halted, output, 1; high in the HALT state.
REQ-017 SHALL have port fault, output, 1; high for a bounds or alignment halt.

Function
REQ-018 SHALL implement the states BOOT, RUN and HALT.
REQ-019 BOOT SHALL last exactly one clock after reset deasserts, with valid=0 and the PC held; the next state is RUN.
REQ-020 In RUN, valid SHALL be 1 and halted SHALL be 0.
REQ-021 In RUN with stall=0, next pc SHALL be selected by priority: reg_branch -> reg_target; uncond_branch -> pc+(branch_offset<<2); cond_branch&zero -> pc+(branch_offset<<2); otherwise pc+4.
REQ-022 cond_branch with zero=0 SHALL yield pc+4.
REQ-023 All PC arithmetic SHALL be `WORD-bit two's complement and wrap modulo 2^`WORD, with no saturation.
REQ-024 In RUN with stall=1, pc SHALL hold and all branch inputs SHALL be ignored that cycle.
REQ-025 halt=1 in RUN SHALL move the state to HALT on the next edge, with pc unchanged; halt overrides stall and all branch inputs in the same cycle.
REQ-026 In HALT, pc SHALL be frozen, valid=0 and halted=1; all inputs are ignored and only reset exits HALT.
REQ-027 halt, stall and branch inputs SHALL be ignored in BOOT.
REQ-028 pc_plus4 SHALL be combinational pc+4 in every state.
REQ-029 The fetch latency SHALL be one clock: the pc produced at edge N is consumed by instruction memory at edge N+1.

Reset
REQ-030 Reset SHALL asynchronously force pc=RESET_PC, state=BOOT, valid=0, halted=0 and fault=0.
REQ-031 Reset asserted mid-branch or mid-stall SHALL discard the pending next-pc; there is no partial update.
REQ-032 Reset deassertion SHALL have no effect until the next rising clk, which moves BOOT to RUN.

Configuration
REQ-033 The macro PC_BOUNDS_CHECK_EN SHALL enable bounds checking.
REQ-034 With PC_BOUNDS_CHECK_EN defined, a non-stalled RUN cycle whose selected next pc has bits [1:0] != 0, or next pc/4 >= IMEM_SIZE, SHALL load no new pc, enter HALT, and set fault=1 until reset.
REQ-035 With PC_BOUNDS_CHECK_EN defined, halt and a fault in the same cycle SHALL set fault=1.
REQ-036 With PC_BOUNDS_CHECK_EN undefined, fault SHALL be tied to 0, no checking logic SHALL exist, and out-of-range pc values SHALL pass through unchanged.

Verification
REQ-037 Reset pulse, then 4 clocks with no control inputs -> pc = 0, 0, 4, 8, with valid going 0 to 1 after BOOT.
REQ-038 pc=0x10, uncond_branch=1, branch_offset=-2 -> next pc=0x08; pc=0x10, cond_branch=1, zero=0 -> next pc=0x14.
REQ-039 pc=0x20, reg_branch=1, uncond_branch=1, reg_target=0x100, branch_offset=5 -> next pc=0x100, confirming priority.
REQ-040 stall=1 for 3 clocks at pc=0x0C with uncond_branch=1 -> pc stays 0x0C; then halt=1 with stall=1 -> HALT, pc=0x0C, valid=0; further clocks leave pc unchanged.
REQ-041 With PC_BOUNDS_CHECK_EN and IMEM_SIZE=1024: reg_target=0x1000 -> HALT with fault=1 and pc unchanged; reg_target=0x102 -> HALT with fault=1; without the macro, both targets are loaded and fault=0.
REQ-042 Reset asserted mid-cycle while halted with fault=1 -> immediately pc=RESET_PC, halted=0, fault=0, valid=0.
